// File: rtl/life_run_ctrl.sv
// Run controller for the Life grid: synchronises the board switches, sequences
// IDLE/SEED/RUN/PAUSE/HALT and paces generation strobes to the grid bank.
module life_run_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int DIV_W       = 24,
    parameter int GEN_W       = 16
) (
    input  logic             clk,
    input  logic             fsmReset,
    input  logic             randSwitch,
    input  logic             startSwitch,
    input  logic             stepBtn,
    input  logic [DIV_W-1:0] divLoad,
    input  logic [GEN_W-1:0] maxGen,
    output logic             floprReset,
    output logic             manualSeed,
    output logic             muxStart,
    output logic             showFloprGridOut,
    output logic             genEn,
    output logic [GEN_W-1:0] genCount,
    output logic             done
);

    typedef enum logic [2:0] {IDLE, SEED, RUN, PAUSE, HALT} state_t;

    state_t                 state, nextState, modeState;
    logic [SYNC_STAGES-1:0] randSync, startSync, stepSync;
    logic                   randS, startS, stepS, stepPrev, stepEdge;
    logic                   limitHit;
    logic [DIV_W-1:0]       divCnt;

    function automatic logic [GEN_W-1:0] satInc(input logic [GEN_W-1:0] v);
        return (&v) ? v : v + GEN_W'(1);
    endfunction

    // Input synchronisers; stepPrev gives a one-shot edge per press.
    always_ff @(posedge clk or posedge fsmReset) begin
        if (fsmReset) begin
            randSync  <= '0;
            startSync <= '0;
            stepSync  <= '0;
            stepPrev  <= 1'b0;
        end else begin
            randSync  <= {randSync[SYNC_STAGES-2:0], randSwitch};
            startSync <= {startSync[SYNC_STAGES-2:0], startSwitch};
            stepSync  <= {stepSync[SYNC_STAGES-2:0], stepBtn};
            stepPrev  <= stepS;
        end
    end

    assign randS    = randSync[SYNC_STAGES-1];
    assign startS   = startSync[SYNC_STAGES-1];
    assign stepS    = stepSync[SYNC_STAGES-1];
    assign stepEdge = stepS & ~stepPrev;

    assign genEn    = ((state == RUN) && (divCnt >= divLoad)) ||
                      ((state == PAUSE) && stepEdge);
    assign limitHit = genEn && (maxGen != '0) &&
                      ((genCount + GEN_W'(1)) == maxGen) && startS;

    always_ff @(posedge clk or posedge fsmReset) begin
        if (fsmReset) state <= IDLE;
        else          state <= nextState;
    end

    always_comb begin
        modeState        = IDLE;
        nextState        = IDLE;
        floprReset       = 1'b1;
        manualSeed       = 1'b1;
        muxStart         = 1'b0;
        showFloprGridOut = 1'b0;
        done             = 1'b0;

        case ({startS, randS})
            2'b00:   modeState = IDLE;
            2'b01:   modeState = SEED;
            2'b10:   modeState = RUN;
            default: modeState = PAUSE;
        endcase

        // HALT only leaves when start drops; rand is then just the seed choice.
        if (state == HALT)
            nextState = startS ? HALT : modeState;
        else if (limitHit)
            nextState = HALT;
        else
            nextState = modeState;

        case (state)
            IDLE: begin
                floprReset = 1'b1;
                manualSeed = 1'b1;
            end
            SEED: begin
                floprReset       = 1'b0;
                manualSeed       = 1'b0;
                showFloprGridOut = 1'b1;
            end
            RUN, PAUSE: begin
                floprReset       = 1'b0;
                manualSeed       = 1'b1;
                muxStart         = 1'b1;
                showFloprGridOut = 1'b1;
            end
            HALT: begin
                floprReset       = 1'b0;
                manualSeed       = 1'b1;
                muxStart         = 1'b1;
                showFloprGridOut = 1'b1;
                done             = 1'b1;
            end
            default: begin
                floprReset = 1'b1;
                manualSeed = 1'b1;
            end
        endcase
    end

    // Generation-period divider, live only while running.
    always_ff @(posedge clk or posedge fsmReset) begin
        if (fsmReset)                       divCnt <= '0;
        else if (state != RUN || genEn)     divCnt <= '0;
        else                                divCnt <= divCnt + DIV_W'(1);
    end

    // Clearing on the way into IDLE/SEED takes priority over a final strobe.
    always_ff @(posedge clk or posedge fsmReset) begin
        if (fsmReset)
            genCount <= '0;
        else if (nextState == IDLE || nextState == SEED)
            genCount <= '0;
        else if (genEn)
            genCount <= satInc(genCount);
    end

endmodule
